// File: rtl/flag_cond_unit.sv
// flag_cond_unit
//   Architectural NZCV flag register plus B.cond resolver for a short
//   in-order pipeline. A branch in ID is resolved in the same cycle from the
//   effective flags. If the EX instruction is writing the flags at the same
//   time, the branch either stalls for one cycle or uses the live ALU flags,
//   depending on the build.
//
//   Build option: define FLAG_COND_FWD_EN to forward the live ALU flags into
//   the condition check. This removes the stall, and WAIT is never entered.
//   When it is undefined, each flag hazard costs exactly one stall cycle.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   alu_negative     N from the EX ALU, current cycle
//   alu_zero         Z from the EX ALU, current cycle
//   alu_overflow     V from the EX ALU, current cycle
//   alu_carry_out    C from the EX ALU, current cycle
//   ex_set_flags     EX instruction writes the flags
//   ex_flush         EX instruction is squashed, so it does not write flags
//   br_valid         ID presents a B.cond
//   br_cond          4-bit condition code
//   br_done          branch resolved this cycle
//   br_taken         resolved condition is true (valid with br_done)
//   br_stall         hold ID/IF this cycle
//   flags_q          architectural flags {N,Z,C,V}
module flag_cond_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_negative,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  input  logic       alu_carry_out,
  input  logic       ex_set_flags,
  input  logic       ex_flush,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic       br_done,
  output logic       br_taken,
  output logic       br_stall,
  output logic [3:0] flags_q
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state;

  logic       flag_wr;
  logic [3:0] alu_flags;
  logic [3:0] eff_flags;
  logic       hazard;

  assign flag_wr   = ex_set_flags & ~ex_flush;
  assign alu_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};

`ifdef FLAG_COND_FWD_EN
  assign eff_flags = flag_wr ? alu_flags : flags_q;
  assign hazard    = 1'b0;
`else
  assign eff_flags = flags_q;
  assign hazard    = br_valid & flag_wr;
`endif

  // Condition codes come in pairs: bits [3:1] select the test and bit 0
  // inverts it. The one exception is 111x, which is always true.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'b000:  base = z;
      3'b001:  base = cy;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = cy & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'b111) ? 1'b1 : (base ^ c[0]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
      state   <= IDLE;
    end else begin
      if (flag_wr) flags_q <= alu_flags;
      case (state)
        IDLE:    if (hazard) state <= WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  // Resolution is combinational so that a branch with no hazard resolves in
  // the same cycle. WAIT evaluates flags_q before the edge. Those are the
  // flags written by the instruction that caused the stall, even if a newer
  // write lands at this edge.
  always_comb begin
    br_done  = 1'b0;
    br_taken = 1'b0;
    br_stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (br_valid) begin
            if (hazard) begin
              br_stall = 1'b1;
            end else begin
              br_done  = 1'b1;
              br_taken = cond_eval(br_cond, eff_flags);
            end
          end
        end
        default: begin
          if (br_valid) begin
            br_done  = 1'b1;
            br_taken = cond_eval(br_cond, flags_q);
          end
        end
      endcase
    end
  end

endmodule
